// File: rtl/ask_demod_param_pkg.sv
// Shared helpers for the ASK/OOK demodulator: width derivations and the peak decay shift.
// The optional adaptive threshold is selected with the ASK_DEMOD_ADAPTIVE_THR_EN macro.
package ask_demod_pkg;

  localparam int PEAK_DECAY_SH = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int env_w(input int din_w);
    return din_w - 1;
  endfunction

  function automatic int acc_w(input int w, input int log2_depth);
    return w + log2_depth;
  endfunction

endpackage

// File: rtl/ask_demod_param_boxcar_lpf.sv
// Boxcar moving-average filter: circular buffer of 2^LOG2_DEPTH samples plus a running sum.
// Buffer starts at zero, so the output ramps up over the first DEPTH samples.
module boxcar_lpf
  import ask_demod_pkg::*;
#(
  parameter int W          = 7,
  parameter int LOG2_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] env_o,
  output logic         env_valid_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = acc_w(W, LOG2_DEPTH);

  logic [W-1:0]          buf_q [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [ACC_W-1:0]      sum_q, sum_d;
  logic                  valid_q;

  always_comb begin
    sum_d = sum_q;
    ptr_d = ptr_q;
    if (valid_i) begin
      // The oldest entry is subtracted before it is overwritten, so the sum never exceeds DEPTH*max.
      sum_d = sum_q + ACC_W'(sample_i) - ACC_W'(buf_q[ptr_q]);
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      valid_q <= valid_i;
      if (valid_i) buf_q[ptr_q] <= sample_i;
    end
  end

  assign env_o       = sum_q[ACC_W-1:LOG2_DEPTH];
  assign env_valid_o = valid_q;

endmodule

// File: rtl/ask_demod_param.sv
// Non-coherent ASK/OOK demodulator: rectifier -> boxcar LPF -> per-symbol slicer.
// Define ASK_DEMOD_ADAPTIVE_THR_EN for a peak-tracking threshold instead of the fixed THRESH.
module ask_demod_param
  import ask_demod_pkg::*;
#(
  parameter int DIN_W        = 8,
  parameter int LOG2_DEPTH   = 4,
  parameter int SPS          = 32,
  parameter int SAMPLE_PHASE = 24,
  parameter int THRESH       = 32,
  localparam int ENV_W       = env_w(DIN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  input  logic             sym_sync,
  output logic [ENV_W-1:0] env_out,
  output logic             env_valid,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [ENV_W-1:0] thr_out
);

  localparam int CNT_W = clog2(SPS);

  logic [ENV_W-1:0] abs_q, abs_d;
  logic             abs_vld_q;
  logic [ENV_W-1:0] env;
  logic             env_vld;
  logic [ENV_W-1:0] thr;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             bit_q, bit_d, bit_vld_q, decide;

  // Magnitude of the most negative input does not fit ENV_W bits, so it saturates.
  always_comb begin
    abs_d = din[ENV_W-1:0];
    if (din[DIN_W-1]) begin
      if (din[ENV_W-1:0] == '0) abs_d = '1;
      else                      abs_d = ~din[ENV_W-1:0] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_q     <= '0;
      abs_vld_q <= 1'b0;
    end else begin
      abs_vld_q <= din_valid;
      if (din_valid) abs_q <= abs_d;
    end
  end

  boxcar_lpf #(.W(ENV_W), .LOG2_DEPTH(LOG2_DEPTH)) u_lpf (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (abs_vld_q),
    .sample_i    (abs_q),
    .env_o       (env),
    .env_valid_o (env_vld)
  );

  // A sync coinciding with a sample makes that sample count 0.
  always_comb begin
    cnt_eff = sym_sync ? '0 : cnt_q;
    decide  = env_vld && (cnt_eff == CNT_W'(SAMPLE_PHASE));
    cnt_d   = cnt_q;
    if (env_vld)       cnt_d = (cnt_eff == CNT_W'(SPS - 1)) ? '0 : cnt_eff + 1'b1;
    else if (sym_sync) cnt_d = '0;
    bit_d = decide ? (env >= thr) : bit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_q     <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      bit_vld_q <= decide;
    end
  end

`ifdef ASK_DEMOD_ADAPTIVE_THR_EN
  logic [ENV_W-1:0] peak_q, peak_d, peak_max;

  // Max-hold first, then a 1/16 decay on decisions so the threshold follows fading amplitude.
  always_comb begin
    peak_max = (env_vld && (env > peak_q)) ? env : peak_q;
    peak_d   = decide ? (peak_max - (peak_max >> PEAK_DECAY_SH)) : peak_max;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign thr = peak_q >> 1;
`else
  assign thr = ENV_W'(THRESH);
`endif

  assign env_out   = env;
  assign env_valid = env_vld;
  assign bit_out   = bit_q;
  assign bit_valid = bit_vld_q;
  assign thr_out   = thr;

endmodule
